riscv_fetch_arbiter: RTL and testbench

RISCV_FETCH_ARBITER -- requirements
Module: riscv_fetch_arbiter

---
 rtl/riscv_defines.sv | 14 +
 rtl/riscv_fetch_arb_idfifo.sv | 55 +++++
 rtl/riscv_fetch_arbiter.sv | 114 +++++++++++
 tb/tb_riscv_fetch_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared types for the instruction fetch arbiter
package riscv_defines;

    typedef logic master_id_t;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } fetch_arb_state_t;

    localparam master_id_t MASTER0 = 1'b0;
    localparam master_id_t MASTER1 = 1'b1;

endpackage

// File: rtl/riscv_fetch_arb_idfifo.sv
// rtl/riscv_fetch_arb_idfifo.sv - in-order FIFO of granted master IDs
module riscv_fetch_arb_idfifo
    import riscv_defines::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  master_id_t push_id,
    input  logic       pop,
    output master_id_t head,
    output logic       full,
    output logic       empty
);

    localparam logic [1:0] LAST    = 2'(DEPTH - 1);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [3:0] mem;
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == 3'd0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_fetch_arbiter.sv
// rtl/riscv_fetch_arbiter.sv - two-master round-robin instruction fetch arbiter (RISCV_FETCH_ARB_PMP_ERR_EN enables error forwarding)
module riscv_fetch_arbiter
    import riscv_defines::*;
#(
    parameter int RDATA_WIDTH     = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m0_req_i,
    input  logic [31:0]            m0_addr_i,
    output logic                   m0_gnt_o,
    output logic                   m0_rvalid_o,
    output logic [RDATA_WIDTH-1:0] m0_rdata_o,
    output logic                   m0_err_o,
    input  logic                   m1_req_i,
    input  logic [31:0]            m1_addr_i,
    output logic                   m1_gnt_o,
    output logic                   m1_rvalid_o,
    output logic [RDATA_WIDTH-1:0] m1_rdata_o,
    output logic                   m1_err_o,
    output logic                   instr_req_o,
    output logic [31:0]            instr_addr_o,
    input  logic                   instr_gnt_i,
    input  logic                   instr_rvalid_i,
    input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
    input  logic                   instr_err_pmp_i,
    output logic                   busy_o
);

    fetch_arb_state_t state_q;
    master_id_t       rr_q;
    master_id_t       hold_id_q;
    logic [31:0]      hold_addr_q;

    master_id_t arb_winner;
    master_id_t winner;
    master_id_t head_id;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    always_comb begin
        arb_winner = MASTER0;
        if (m0_req_i && m1_req_i) arb_winner = rr_q;
        else if (m1_req_i)        arb_winner = MASTER1;
    end

    // A stalled request is frozen on the latched master and address until granted
    assign winner       = (state_q == HOLD) ? hold_id_q : arb_winner;
    assign instr_req_o  = ~rst & ((state_q == HOLD) | ((m0_req_i | m1_req_i) & ~fifo_full));
    assign instr_addr_o = (state_q == HOLD)     ? hold_addr_q :
                          (winner == MASTER1)   ? m1_addr_i   : m0_addr_i;

    assign push = instr_req_o & instr_gnt_i;
    assign pop  = ~rst & instr_rvalid_i & ~fifo_empty;

    assign m0_gnt_o    = push & (winner == MASTER0);
    assign m1_gnt_o    = push & (winner == MASTER1);
    assign m0_rvalid_o = pop & (head_id == MASTER0);
    assign m1_rvalid_o = pop & (head_id == MASTER1);
    assign m0_rdata_o  = instr_rdata_i;
    assign m1_rdata_o  = instr_rdata_i;
    assign busy_o      = ~rst & (instr_req_o | ~fifo_empty);

`ifdef RISCV_FETCH_ARB_PMP_ERR_EN
    assign m0_err_o = instr_err_pmp_i & m0_rvalid_o;
    assign m1_err_o = instr_err_pmp_i & m1_rvalid_o;
`else
    logic unused_err_pmp;
    assign unused_err_pmp = instr_err_pmp_i;
    assign m0_err_o       = 1'b0;
    assign m1_err_o       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            rr_q        <= MASTER0;
            hold_id_q   <= MASTER0;
            hold_addr_q <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (instr_req_o && !instr_gnt_i) begin
                        state_q     <= HOLD;
                        hold_id_q   <= arb_winner;
                        hold_addr_q <= instr_addr_o;
                    end
                end
                HOLD: begin
                    if (instr_gnt_i) state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
            if (push) rr_q <= ~winner;
        end
    end

    riscv_fetch_arb_idfifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_idfifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_id (winner),
        .pop     (pop),
        .head    (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_riscv_fetch_arbiter.sv
// tb/tb_riscv_fetch_arbiter.sv - directed self-checking bench for riscv_fetch_arbiter
module tb_riscv_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i, instr_rvalid_i, instr_err_pmp_i;
    logic [31:0] instr_rdata_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

`ifdef RISCV_FETCH_ARB_PMP_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    riscv_fetch_arbiter #(
        .RDATA_WIDTH     (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .m0_req_i        (m0_req_i),
        .m0_addr_i       (m0_addr_i),
        .m0_gnt_o        (m0_gnt_o),
        .m0_rvalid_o     (m0_rvalid_o),
        .m0_rdata_o      (m0_rdata_o),
        .m0_err_o        (m0_err_o),
        .m1_req_i        (m1_req_i),
        .m1_addr_i       (m1_addr_i),
        .m1_gnt_o        (m1_gnt_o),
        .m1_rvalid_o     (m1_rvalid_o),
        .m1_rdata_o      (m1_rdata_o),
        .m1_err_o        (m1_err_o),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_err_pmp_i (instr_err_pmp_i),
        .busy_o          (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                         input logic gnt, input logic rv, input logic [31:0] rd, input logic err);
        m0_req_i        = r0;
        m0_addr_i       = a0;
        m1_req_i        = r1;
        m1_addr_i       = a1;
        instr_gnt_i     = gnt;
        instr_rvalid_i  = rv;
        instr_rdata_i   = rd;
        instr_err_pmp_i = err;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic g0, input logic g1);
        check({tag, "_m0_gnt"}, 32'(m0_gnt_o), 32'(g0));
        check({tag, "_m1_gnt"}, 32'(m1_gnt_o), 32'(g1));
    endtask

    task automatic chk_rv(input string tag, input logic v0, input logic v1);
        check({tag, "_m0_rvalid"}, 32'(m0_rvalid_o), 32'(v0));
        check({tag, "_m1_rvalid"}, 32'(m1_rvalid_o), 32'(v1));
    endtask

    initial begin
        // reset with requests pending: everything quiet
        rst = 1'b1;
        drive(1, 32'h100, 1, 32'h200, 1, 1, 32'h0, 1);
        check("rst_req", 32'(instr_req_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        chk_gnt("rst", 0, 0);
        chk_rv("rst", 0, 0);
        step();
        step();
        rst = 1'b0;

        // round-robin alternation with one-cycle response latency
        drive(1, 32'h100, 1, 32'h200, 1, 0, 32'h0, 0);
        chk_gnt("rr_a", 1, 0);
        check("rr_a_addr", instr_addr_o, 32'h100);
        step();
        drive(1, 32'h100, 1, 32'h200, 1, 1, 32'h11, 0);
        chk_gnt("rr_b", 0, 1);
        check("rr_b_addr", instr_addr_o, 32'h200);
        chk_rv("rr_b", 1, 0);
        check("rr_b_rdata0", m0_rdata_o, 32'h11);
        step();
        drive(1, 32'h100, 1, 32'h200, 1, 1, 32'h22, 0);
        chk_gnt("rr_c", 1, 0);
        chk_rv("rr_c", 0, 1);
        check("rr_c_rdata1", m1_rdata_o, 32'h22);
        step();
        drive(1, 32'h100, 1, 32'h200, 1, 1, 32'h33, 0);
        chk_gnt("rr_d", 0, 1);
        chk_rv("rr_d", 1, 0);
        step();
        drive(0, 32'h100, 0, 32'h200, 0, 1, 32'h44, 0);
        check("rr_e_req", 32'(instr_req_o), 0);
        check("rr_e_busy", 32'(busy_o), 1);
        chk_rv("rr_e", 0, 1);
        step();
        drive(0, 32'h100, 0, 32'h200, 0, 0, 32'h0, 0);
        check("idle_busy", 32'(busy_o), 0);

        // stalled m1 request holds address while m0 joins
        drive(0, 32'h300, 1, 32'h1A110800, 0, 0, 32'h0, 0);
        check("hold1_req", 32'(instr_req_o), 1);
        check("hold1_addr", instr_addr_o, 32'h1A110800);
        chk_gnt("hold1", 0, 0);
        step();
        drive(1, 32'h300, 1, 32'h1A110800, 0, 0, 32'h0, 0);
        check("hold2_addr", instr_addr_o, 32'h1A110800);
        step();
        drive(1, 32'h300, 1, 32'h1A110800, 0, 0, 32'h0, 0);
        check("hold3_addr", instr_addr_o, 32'h1A110800);
        chk_gnt("hold3", 0, 0);
        step();
        drive(1, 32'h300, 1, 32'h1A110800, 1, 0, 32'h0, 0);
        check("hold4_addr", instr_addr_o, 32'h1A110800);
        chk_gnt("hold4", 0, 1);
        step();
        drive(1, 32'h300, 0, 32'h1A110800, 1, 0, 32'h0, 0);
        check("after_hold_addr", instr_addr_o, 32'h300);
        chk_gnt("after_hold", 1, 0);
        step();

        // FIFO full (m1, m0): request blocked, no bypass on same-cycle pop
        drive(1, 32'h300, 0, 32'h0, 1, 0, 32'h0, 0);
        check("full_req", 32'(instr_req_o), 0);
        check("full_busy", 32'(busy_o), 1);
        chk_gnt("full", 0, 0);
        step();
        drive(1, 32'h300, 0, 32'h0, 1, 1, 32'hCAFE, 0);
        check("full_pop_req", 32'(instr_req_o), 0);
        chk_rv("full_pop", 0, 1);
        step();
        drive(1, 32'h304, 0, 32'h0, 1, 0, 32'h0, 0);
        check("regrant_req", 32'(instr_req_o), 1);
        chk_gnt("regrant", 1, 0);
        step();
        drive(1, 32'h308, 0, 32'h0, 1, 0, 32'h0, 0);
        check("refull_req", 32'(instr_req_o), 0);
        step();
        drive(0, 32'h0, 0, 32'h0, 0, 1, 32'h5, 1);
        chk_rv("drain1", 1, 0);
        check("drain1_m0_err", 32'(m0_err_o), 32'(ERR_EXP));
        check("drain1_m1_err", 32'(m1_err_o), 0);
        step();
        drive(0, 32'h0, 0, 32'h0, 0, 1, 32'h6, 0);
        chk_rv("drain2", 1, 0);
        step();

        // response with nothing outstanding is dropped
        drive(0, 32'h0, 0, 32'h0, 0, 1, 32'hDEADBEEF, 1);
        chk_rv("empty_rv", 0, 0);
        check("empty_busy", 32'(busy_o), 0);
        check("empty_rdata0", m0_rdata_o, 32'hDEADBEEF);
        check("empty_err1", 32'(m1_err_o), 0);
        step();

        // PMP error routed to the m1 fetch only
        drive(0, 32'h0, 1, 32'h400, 1, 0, 32'h0, 0);
        chk_gnt("err_g", 0, 1);
        step();
        drive(0, 32'h0, 0, 32'h0, 0, 1, 32'h77, 1);
        chk_rv("err_rv", 0, 1);
        check("err_m1", 32'(m1_err_o), 32'(ERR_EXP));
        check("err_m0", 32'(m0_err_o), 0);
        step();

        // reset with two outstanding, pointer left at m1
        drive(0, 32'h0, 1, 32'h500, 1, 0, 32'h0, 0);
        chk_gnt("pre_rst_a", 0, 1);
        step();
        drive(1, 32'h600, 0, 32'h0, 1, 0, 32'h0, 0);
        chk_gnt("pre_rst_b", 1, 0);
        step();
        rst = 1'b1;
        drive(1, 32'h600, 1, 32'h500, 1, 0, 32'h0, 0);
        check("mid_rst_req", 32'(instr_req_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        step();
        rst = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0, 1, 32'h88, 0);
        chk_rv("post_rst_rv", 0, 0);
        check("post_rst_busy", 32'(busy_o), 0);
        step();
        drive(1, 32'h600, 1, 32'h500, 1, 0, 32'h0, 0);
        chk_gnt("post_rst_arb", 1, 0);
        check("post_rst_addr", instr_addr_o, 32'h600);
        step();
        drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
